// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU with single-cycle ops and an iterative shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             c_flag,
  output logic             err
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d, acc_nx;
  logic [WIDTH-1:0]     mplier_q, mplier_d, result_q, result_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d, z_q, z_d, c_q, c_d, err_q, err_d;
  logic [WIDTH:0]       alu;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      z_q      <= z_d;
      c_q      <= c_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    z_d      = z_q;
    c_d      = c_q;
    err_d    = err_q;
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // bit WIDTH carries the carry/borrow/shift-out for the single-cycle ops
    case (op)
      4'd1:    alu = {1'b0, bus};
      4'd2:    alu = {1'b0, ac} + {1'b0, bus};
      4'd3:    alu = {1'b0, ac} - {1'b0, bus};
      4'd5:    alu = {1'b0, ac} + (WIDTH+1)'(1);
      4'd7:    alu = {1'b0, ac ^ bus};
      4'd8:    alu = {1'b0, ac & bus};
      4'd9:    alu = {1'b0, ac | bus};
      4'd10:   alu = {ac, 1'b0};
      4'd11:   alu = {ac[0], 1'b0, ac[WIDTH-1:1]};
      default: alu = '0;
    endcase
    if (state_q == S_IDLE && start) begin
      if (op == 4'd4) begin
        state_d  = S_MUL;
        mcand_d  = {{WIDTH{1'b0}}, ac};
        mplier_d = bus;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        done_d = 1'b1;
        err_d  = op > 4'd11;
        if (op != 4'd0 && op <= 4'd11) begin
          result_d = alu[WIDTH-1:0];
          c_d      = alu[WIDTH];
          z_d      = ~|alu[WIDTH-1:0];
        end
      end
    end else if (state_q == S_MUL) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        err_d    = 1'b0;
        result_d = acc_nx[WIDTH-1:0];
        c_d      = |acc_nx[2*WIDTH-1:WIDTH];
        z_d      = ~|acc_nx[WIDTH-1:0];
      end
    end
  end
  assign busy   = state_q == S_MUL;
  assign done   = done_q;
  assign result = result_q;
  assign z_flag = z_q;
  assign c_flag = c_q;
  assign err    = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=12.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [11:0] ac = '0, bus = '0;
  logic        busy, done, z_flag, c_flag, err;
  logic [11:0] result;
  logic [16:0] st;
  int          n_checks = 0, n_fail = 0;
  alu_seq #(.WIDTH(12)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .ac(ac), .bus(bus),
    .busy(busy), .done(done), .result(result), .z_flag(z_flag), .c_flag(c_flag), .err(err)
  );
  always #5 clk = ~clk;
  // status word: {done, busy, err, z, c, result}
  assign st = {done, busy, err, z_flag, c_flag, result};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [3:0] o, input logic [11:0] a, input logic [11:0] b);
    op = o; ac = a; bus = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 4'd1; bus = 12'h123;
    tick(); tick();
    n_checks++;
    if (st !== 17'h0) begin n_fail++; $display("FAIL reset_state: got %h exp %h", st, 17'h0); end
    reset = 1'b0; start = 1'b0;
    tick();
    n_checks++;
    if (st !== 17'h0) begin n_fail++; $display("FAIL reset_idle: got %h exp %h", st, 17'h0); end
  endtask
  task automatic test_add();
    do_op(4'd2, 12'hFFF, 12'h001);
    n_checks++;
    if (st !== {5'b10011, 12'h000}) begin n_fail++; $display("FAIL add_wrap: got %h exp %h", st, {5'b10011, 12'h000}); end
    tick();
    n_checks++;
    if (st !== {5'b00011, 12'h000}) begin n_fail++; $display("FAIL add_hold: got %h exp %h", st, {5'b00011, 12'h000}); end
  endtask
  task automatic test_sub_shr();
    do_op(4'd3, 12'h005, 12'h007);
    n_checks++;
    if (st !== {5'b10001, 12'hFFE}) begin n_fail++; $display("FAIL sub_borrow: got %h exp %h", st, {5'b10001, 12'hFFE}); end
    do_op(4'd11, 12'h003, 12'h000);
    n_checks++;
    if (st !== {5'b10001, 12'h001}) begin n_fail++; $display("FAIL shr: got %h exp %h", st, {5'b10001, 12'h001}); end
  endtask
  task automatic test_logic();
    logic [3:0]  ops [7]  = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd5, 4'd6, 4'd1};
    logic [11:0] as  [7]  = '{12'hF0F, 12'hF0F, 12'hF0F, 12'h801, 12'hFFF, 12'h123, 12'h000};
    logic [11:0] bs  [7]  = '{12'h0FF, 12'h0FF, 12'h0FF, 12'h000, 12'h000, 12'h456, 12'h800};
    logic [16:0] exp [7]  = '{{5'b10000, 12'hFF0}, {5'b10000, 12'h00F}, {5'b10000, 12'hFFF},
                              {5'b10001, 12'h002}, {5'b10011, 12'h000}, {5'b10010, 12'h000},
                              {5'b10000, 12'h800}};
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i]);
      n_checks++;
      if (st !== exp[i]) begin n_fail++; $display("FAIL logic_op%0d: got %h exp %h", ops[i], st, exp[i]); end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{4'd2, 4'd3, 4'd5};
    logic [11:0] as  [3] = '{12'h001, 12'h003, 12'h007};
    logic [11:0] bs  [3] = '{12'h002, 12'h001, 12'h000};
    logic [11:0] exp [3] = '{12'h003, 12'h002, 12'h008};
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; ac = as[i]; bus = bs[i];
      tick();
      n_checks++;
      if (st !== {5'b10000, exp[i]}) begin n_fail++; $display("FAIL b2b_%0d: got %h exp %h", i, st, {5'b10000, exp[i]}); end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clear: got %b exp 0", done); end
  endtask
  task automatic test_nop();
    do_op(4'd10, 12'h801, 12'h000);
    do_op(4'd0, 12'hFFF, 12'hFFF);
    n_checks++;
    if (st !== {5'b10001, 12'h002}) begin n_fail++; $display("FAIL nop: got %h exp %h", st, {5'b10001, 12'h002}); end
  endtask
  task automatic test_mul();
    do_op(4'd4, 12'h00C, 12'h00A);
    ac = 12'hFFF; bus = 12'hFFF;
    for (int i = 1; i <= 12; i++) begin
      n_checks++;
      if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL mul_busy_c%0d: got %b exp 01", i, {done, busy}); end
      tick();
    end
    n_checks++;
    if (st !== {5'b10000, 12'h078}) begin n_fail++; $display("FAIL mul_12x10: got %h exp %h", st, {5'b10000, 12'h078}); end
    do_op(4'd4, 12'h100, 12'h010);
    for (int i = 0; i < 20 && !done; i++) tick();
    n_checks++;
    if (st !== {5'b10011, 12'h000}) begin n_fail++; $display("FAIL mul_overflow: got %h exp %h", st, {5'b10011, 12'h000}); end
  endtask
  task automatic test_mul_ignore();
    int dones = 0;
    do_op(4'd4, 12'h00C, 12'h00A);
    tick(); tick(); tick();
    do_op(4'd2, 12'h111, 12'h222);
    for (int i = 5; i <= 12; i++) begin
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL mul_ignore_spurious: got %0d dones exp 0", dones); end
    n_checks++;
    if (st !== {5'b10000, 12'h078}) begin n_fail++; $display("FAIL mul_ignore_result: got %h exp %h", st, {5'b10000, 12'h078}); end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL mul_ignore_after: got %b exp 00", {done, busy}); end
  endtask
  task automatic test_mul_reset();
    int dones = 0;
    do_op(4'd10, 12'h801, 12'h000);
    do_op(4'd4, 12'h00C, 12'h00A);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (st !== 17'h0) begin n_fail++; $display("FAIL mul_abort_state: got %h exp %h", st, 17'h0); end
    for (int i = 6; i <= 20; i++) begin
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL mul_abort_done: got %0d dones exp 0", dones); end
  endtask
  task automatic test_illegal();
    do_op(4'd10, 12'h801, 12'h000);
    do_op(4'hE, 12'h0F0, 12'h0F0);
    n_checks++;
    if (st !== {5'b10101, 12'h002}) begin n_fail++; $display("FAIL illegal: got %h exp %h", st, {5'b10101, 12'h002}); end
    tick();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_hold: got %b exp 1", err); end
    do_op(4'd1, 12'h000, 12'h5A5);
    n_checks++;
    if (st !== {5'b10000, 12'h5A5}) begin n_fail++; $display("FAIL illegal_clear: got %h exp %h", st, {5'b10000, 12'h5A5}); end
  endtask
  initial begin
    #1;
    test_reset();
    test_add();
    test_sub_shr();
    test_logic();
    test_back_to_back();
    test_nop();
    test_mul();
    test_mul_ignore();
    test_mul_reset();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, datapath width in bits (legal range 4..32).
REQ-002 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to perform op; sampled on rising clk edges.
REQ-005 SHALL provide port op  input  4  operation code, sampled with start.
REQ-006 SHALL provide port ac  input  WIDTH  accumulator operand, sampled with start.
REQ-007 SHALL provide port bus  input  WIDTH  bus operand, sampled with start.
REQ-008 SHALL provide port busy  output  1  high while a multi-cycle multiply is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse: result/flags updated this cycle.
REQ-010 SHALL provide port result  output  WIDTH  registered result, held between operations.
REQ-011 SHALL provide port z_flag  output  1  result of last completed op equals zero.
REQ-012 SHALL provide port c_flag  output  1  carry/borrow/shift-out/overflow of last completed op.
REQ-013 SHALL provide port err  output  1  last accepted op code was illegal.

Function
REQ-014 SHALL decode op: 0 NOP, 1 PASS(bus), 2 ADD(ac+bus), 3 SUB(ac-bus), 4 MUL(ac*bus), 5 INC(ac+1), 6 ZERO, 7 XOR, 8 AND, 9 OR, 10 SHL(ac<<1), 11 SHR(ac>>1, logical); 12-15 illegal.
REQ-015 SHALL accept start only in state IDLE; start while busy=1 is ignored, produces no done, and does not disturb the running multiply.
REQ-016 SHALL capture op, ac, bus on the accepting edge; later operand changes have no effect on that operation.
REQ-017 Single-cycle ops (all except MUL) SHALL have latency 1: start in cycle N -> done=1, result and flags valid in cycle N+1; back-to-back starts every cycle SHALL be supported.
REQ-018 State machine SHALL have states IDLE and MUL; IDLE->MUL on accepted MUL start; MUL->IDLE after exactly WIDTH iterations; reset forces IDLE.
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; start in cycle N -> busy=1 in cycles N+1..N+WIDTH, done=1 and busy=0 in cycle N+WIDTH+1.
REQ-020 MUL result SHALL be product[WIDTH-1:0]; c_flag SHALL be 1 iff product[2*WIDTH-1:WIDTH] is nonzero.
REQ-021 ADD/INC c_flag SHALL be carry-out of the WIDTH-bit sum; SUB c_flag SHALL be 1 iff ac < bus (unsigned borrow); all arithmetic wraps modulo 2^WIDTH.
REQ-022 SHL c_flag SHALL be ac[WIDTH-1]; SHR c_flag SHALL be ac[0]; PASS/ZERO/XOR/AND/OR c_flag SHALL be 0.
REQ-023 z_flag SHALL be 1 iff the new result is all zeros; z_flag and c_flag update only in a done cycle.
REQ-024 NOP SHALL pulse done with result, z_flag, c_flag unchanged and err=0.
REQ-025 Illegal op SHALL pulse done with err=1, result and flags unchanged; err SHALL clear at the next done of a legal op.
REQ-026 done SHALL be high for exactly one cycle per accepted start and never otherwise.
REQ-027 result, z_flag, c_flag SHALL hold their values indefinitely when no operation completes.

Reset
REQ-028 reset SHALL take effect on the rising clk edge it is high and dominate start.
REQ-029 After reset: state IDLE, busy=0, done=0, result=0, z_flag=0, c_flag=0, err=0, multiply accumulator and counter cleared.
REQ-030 reset during MUL SHALL abort it; no done SHALL be produced for the aborted operation.

Verification (WIDTH=12)
REQ-031 ADD ac=0xFFF bus=0x001 start in cycle N -> cycle N+1: done=1, result=0x000, z_flag=1, c_flag=1.
REQ-032 SUB ac=0x005 bus=0x007 -> next cycle: result=0xFFE, c_flag=1, z_flag=0; then SHR ac=0x003 -> result=0x001, c_flag=1.
REQ-033 MUL ac=0x00C bus=0x00A start in cycle N -> busy=1 cycles N+1..N+12, done=1 cycle N+13, result=0x078, c_flag=0; MUL ac=0x100 bus=0x010 -> result=0x000, z_flag=1, c_flag=1.
REQ-034 ADD start (operands changed) in cycle N+4 of a running MUL -> ignored; single done at N+13 with MUL result 0x078.
REQ-035 reset high in cycle N+5 of a running MUL -> cycle N+6: busy=0, result=0, all flags 0; no done through N+20.
REQ-036 op=0xE start -> next cycle done=1, err=1, result unchanged; following legal PASS bus=0x5A5 -> err=0, result=0x5A5.
